// File: rtl/demux_rr_if.sv
// Producer / scheduler / consumer signal bundle for the 1-to-4 demux scheduler.
interface demux_rr_if #(
  parameter int W     = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic [1:0]       in_dest;
  logic             in_ready;
  logic             dir_mode;
  logic [3:0]       chan_mask;
  logic [1:0]       sel;
  logic             en;
  logic [W-1:0]     out_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [CNT_W-1:0] xfer_cnt;
  logic             drop_pulse;
  logic             timeout_err;

  modport master (
    output in_valid, in_data, in_dest, dir_mode, chan_mask, out_ready,
    input  in_ready, sel, en, out_data, out_valid, xfer_cnt, drop_pulse, timeout_err
  );

  modport slave (
    input  in_valid, in_data, in_dest, dir_mode, chan_mask, out_ready,
    output in_ready, sel, en, out_data, out_valid, xfer_cnt, drop_pulse, timeout_err
  );
endinterface

// File: rtl/demux_rr_scheduler.sv
// Holds one producer word at a time and steers it through a 1-to-4 demux,
// choosing the channel round-robin or from in_dest, with a stall timeout.
module demux_rr_scheduler #(
  parameter int W       = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic      clk,
  input  logic      rst,
  demux_rr_if.slave bus
);
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // state | meaning
  // IDLE  | no word held, demux disabled
  // HOLD  | word held on out_data, demux enabled toward sel
  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state, state_nxt;
  logic [1:0]          sel_q, sel_nxt, rr_ptr, ptr_nxt, base, rr_ch, idx, pick_ch;
  logic [W-1:0]        data_q, data_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
  logic                drop_q, drop_nxt, err_q, err_nxt;
  logic                can_accept, xfer, found, pick_ok, ready_c, en_c;
  logic [3:0]          valid_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= '0;
      data_q   <= '0;
      rr_ptr   <= '0;
      cnt_q    <= '0;
      wait_cnt <= '0;
      drop_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel_q    <= sel_nxt;
      data_q   <= data_nxt;
      rr_ptr   <= ptr_nxt;
      cnt_q    <= cnt_nxt;
      wait_cnt <= wait_nxt;
      drop_q   <= drop_nxt;
      err_q    <= err_nxt;
    end
  end

  // A back-to-back accept must scan from the channel just served, not the stale pointer.
  always_comb begin
    can_accept = bus.dir_mode | (|bus.chan_mask);
    xfer       = (state == HOLD) & bus.out_ready[sel_q];
    base       = (xfer & ~bus.dir_mode) ? sel_q : rr_ptr;
    rr_ch      = base;
    found      = 1'b0;
    idx        = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = base + 2'(i);
      if (!found && bus.chan_mask[idx]) begin
        rr_ch = idx;
        found = 1'b1;
      end
    end
    pick_ch = bus.dir_mode ? bus.in_dest : rr_ch;
    pick_ok = bus.dir_mode ? bus.chan_mask[bus.in_dest] : 1'b1;
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    data_nxt  = data_q;
    ptr_nxt   = rr_ptr;
    cnt_nxt   = cnt_q;
    wait_nxt  = wait_cnt;
    drop_nxt  = 1'b0;
    err_nxt   = err_q;
    ready_c   = 1'b0;
    en_c      = 1'b0;
    valid_c   = 4'b0000;
    case (state)
      IDLE: ready_c = can_accept & ~rst;
      HOLD: begin
        en_c    = 1'b1;
        valid_c = 4'b0001 << sel_q;
        ready_c = xfer & can_accept & ~rst;
        if (xfer) begin
          cnt_nxt   = cnt_q + CNT_W'(1);
          state_nxt = IDLE;
          if (!bus.dir_mode) ptr_nxt = sel_q;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          drop_nxt  = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.in_valid && ready_c) begin
      if (pick_ok) begin
        state_nxt = HOLD;
        sel_nxt   = pick_ch;
        data_nxt  = bus.in_data;
        wait_nxt  = '0;
      end else begin
        drop_nxt = 1'b1;
      end
    end
  end

  assign bus.in_ready    = ready_c;
  assign bus.en          = en_c;
  assign bus.out_valid   = valid_c;
  assign bus.sel         = sel_q;
  assign bus.out_data    = data_q;
  assign bus.xfer_cnt    = cnt_q;
  assign bus.drop_pulse  = drop_q;
  assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Directed and random stimulus for demux_rr_scheduler, checked every cycle against a word-level model.
module tb_demux_rr_scheduler;
  localparam int W       = 8;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  demux_rr_if #(.W(W), .CNT_W(CNT_W)) bus ();

  demux_rr_scheduler #(.W(W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // model: at most one word in flight, its channel, age and the round-robin pointer
  bit     m_busy, m_err, m_drop;
  int     m_ch, m_age, m_ptr, m_cnt;
  byte    m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit can_take();
    return bus.dir_mode || (bus.chan_mask != 4'b0000);
  endfunction

  task automatic model_edge();
    int ch;
    bit nd, free;
    if (rst) begin
      m_busy = 0; m_ch = 0; m_data = 0; m_age = 0; m_ptr = 0; m_cnt = 0; m_err = 0; m_drop = 0;
      return;
    end
    nd   = 0;
    free = !m_busy;
    if (m_busy) begin
      if (bus.out_ready[m_ch]) begin
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (!bus.dir_mode) m_ptr = m_ch;
        m_busy = 0;
        free = 1;
      end else begin
        m_age++;
        if (m_age == TIMEOUT) begin
          m_busy = 0; nd = 1; m_err = 1;
        end
      end
    end
    if (free && bus.in_valid && can_take()) begin
      ch = -1;
      if (bus.dir_mode) begin
        if (bus.chan_mask[bus.in_dest]) ch = int'(bus.in_dest);
        else nd = 1;
      end else begin
        for (int k = 1; k <= 4; k++)
          if (ch < 0 && bus.chan_mask[(m_ptr + k) % 4]) ch = (m_ptr + k) % 4;
      end
      if (ch >= 0) begin
        m_busy = 1; m_ch = ch; m_data = bus.in_data; m_age = 0;
      end
    end
    m_drop = nd;
  endtask

  task automatic cycle();
    logic exp_ready;
    @(negedge clk);
    if (rst) exp_ready = 1'b0;
    else if (!m_busy) exp_ready = can_take();
    else exp_ready = bus.out_ready[m_ch] && can_take();
    chk("en", bus.en, m_busy);
    chk("sel", bus.sel, m_ch);
    chk("out_valid", bus.out_valid, m_busy ? (32'd1 << m_ch) : 32'd0);
    chk("out_data", bus.out_data, 32'(m_data) & 32'hff);
    chk("xfer_cnt", bus.xfer_cnt, m_cnt);
    chk("drop_pulse", bus.drop_pulse, m_drop);
    chk("timeout_err", bus.timeout_err, m_err);
    chk("in_ready", bus.in_ready, exp_ready);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[8];
    int n, saved;
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 8'h00; bus.in_dest = 2'd0;
    bus.dir_mode = 1'b0; bus.chan_mask = 4'hF; bus.out_ready = 4'h0;
    @(posedge clk);
    model_edge();
    #1;

    // T1 reset with in_valid high
    cycle();
    cycle();
    chk("t1_ready_in_rst", bus.in_ready, 1'b0);
    chk("t1_en", bus.en, 1'b0);
    chk("t1_valid", bus.out_valid, 4'b0000);
    rst = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("t1_ready_after", bus.in_ready, 1'b1);

    // T2 round robin, all channels, back-to-back
    exp_seq = '{1, 2, 3, 0, 1, 2, 3, 0};
    bus.out_ready = 4'hF;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(8'h10 + i);
      cycle();
      chk("t2_sel", bus.sel, exp_seq[i]);
      chk("t2_no_bubble", bus.en, 1'b1);
    end
    bus.in_valid = 1'b0;
    cycle();
    chk("t2_cnt", bus.xfer_cnt, 8);

    // T3 masked round robin, then empty mask
    exp_seq = '{2, 0, 2, 0, 0, 0, 0, 0};
    bus.chan_mask = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(8'h20 + i);
      cycle();
      chk("t3_sel", bus.sel, exp_seq[i]);
    end
    bus.in_valid = 1'b0;
    cycle();
    bus.chan_mask = 4'b0000; bus.in_valid = 1'b1;
    repeat (3) cycle();
    chk("t3_ready", bus.in_ready, 1'b0);
    chk("t3_en", bus.en, 1'b0);

    // T4 directed, then directed to a masked channel
    bus.dir_mode = 1'b1; bus.in_dest = 2'd3; bus.chan_mask = 4'hF;
    bus.out_ready = 4'h0; bus.in_data = 8'hA5;
    cycle();
    bus.in_valid = 1'b0;
    chk("t4_sel", bus.sel, 2'd3);
    chk("t4_valid", bus.out_valid, 4'b1000);
    bus.out_ready = 4'hF;
    cycle();
    saved = int'(bus.xfer_cnt);
    bus.in_valid = 1'b1; bus.in_dest = 2'd1; bus.chan_mask = 4'b1101;
    cycle();
    bus.in_valid = 1'b0;
    chk("t4_drop", bus.drop_pulse, 1'b1);
    chk("t4_cnt_same", bus.xfer_cnt, saved);
    chk("t4_en", bus.en, 1'b0);
    cycle();

    // T5 timeout after TIMEOUT cycles of stall
    bus.dir_mode = 1'b0; bus.chan_mask = 4'hF; bus.out_ready = 4'h0;
    bus.in_valid = 1'b1; bus.in_data = 8'h55;
    cycle();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.en === 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    chk("t5_hold_len", n, TIMEOUT);
    chk("t5_drop", bus.drop_pulse, 1'b1);
    chk("t5_err", bus.timeout_err, 1'b1);
    cycle();
    chk("t5_err_sticky", bus.timeout_err, 1'b1);

    // T5b ready arrives after 10 stalled cycles
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h66;
    cycle();
    bus.in_valid = 1'b0;
    repeat (10) cycle();
    bus.out_ready = 4'hF;
    cycle();
    chk("t5b_cnt", bus.xfer_cnt, 1);
    chk("t5b_err", bus.timeout_err, 1'b0);
    chk("t5b_en", bus.en, 1'b0);

    // T6 counter wrap, then reset while holding
    rst = 1'b1;
    cycle();
    rst = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.in_data = 8'(i);
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();
    chk("t6_wrap", bus.xfer_cnt, 1);
    bus.out_ready = 4'h0; bus.in_valid = 1'b1; bus.in_data = 8'h77;
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    chk("t6_holding", bus.en, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_rst_en", bus.en, 1'b0);
    chk("t6_rst_drop", bus.drop_pulse, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(63) == 0);
      bus.in_valid = $urandom_range(3) != 0;
      bus.in_data = 8'($urandom);
      bus.in_dest = 2'($urandom);
      if ($urandom_range(15) == 0) bus.dir_mode = ~bus.dir_mode;
      if ($urandom_range(7) == 0) bus.chan_mask = 4'($urandom);
      bus.out_ready = ($urandom_range(3) != 0) ? 4'($urandom) : 4'h0;
      cycle();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
